// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : button_debouncer
// Purpose  : Two-flop synchronizer plus saturating-counter debounce FSM for a
//            raw push-button. Produces a clean level, its complement,
//            rise/fall strobes and a press-toggled level, all registered.
// Revision : 1.0  initial release
// ============================================================================
module button_debouncer #(
    parameter int STABLE_COUNT = 1000000,
    parameter int CNT_WIDTH    = 20
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic Button,
    output logic Clean,
    output logic notClean,
    output logic Rise,
    output logic Fall,
    output logic Toggle
);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] c_STABLE = CNT_WIDTH'(STABLE_COUNT);
    localparam logic [CNT_WIDTH-1:0] c_ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_ZERO   = '0;

    logic                 r_sync1;
    logic                 r_sync2;
    state_t               r_state;
    state_t               w_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt;
    logic                 r_clean;
    logic                 w_clean;
    logic                 r_rise;
    logic                 w_rise;
    logic                 r_fall;
    logic                 w_fall;
    logic                 r_toggle;
    logic                 w_toggle;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_state  <= IDLE_LOW;
            r_cnt    <= c_ZERO;
            r_clean  <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_toggle <= 1'b0;
        end else begin
            r_sync1  <= Button;
            r_sync2  <= r_sync1;
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_clean  <= w_clean;
            r_rise   <= w_rise;
            r_fall   <= w_fall;
            r_toggle <= w_toggle;
        end
    end

    // Decisions use the pre-edge synchronized level, so a change landing on
    // the qualifying edge cannot cancel an exit already earned.
    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_clean  = r_clean;
        w_rise   = 1'b0;
        w_fall   = 1'b0;
        w_toggle = r_toggle;
        case (r_state)
            IDLE_LOW: begin
                if (r_sync2) begin
                    w_state = WAIT_HIGH;
                    w_cnt   = c_ONE;
                end else begin
                    w_cnt   = c_ZERO;
                end
            end
            WAIT_HIGH: begin
                if (!r_sync2) begin
                    w_state = IDLE_LOW;
                    w_cnt   = c_ZERO;
                end else if (r_cnt == c_STABLE) begin
                    w_state  = IDLE_HIGH;
                    w_cnt    = c_ZERO;
                    w_clean  = 1'b1;
                    w_rise   = 1'b1;
                    w_toggle = ~r_toggle;
                end else begin
                    w_cnt = r_cnt + c_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!r_sync2) begin
                    w_state = WAIT_LOW;
                    w_cnt   = c_ONE;
                end else begin
                    w_cnt   = c_ZERO;
                end
            end
            WAIT_LOW: begin
                if (r_sync2) begin
                    w_state = IDLE_HIGH;
                    w_cnt   = c_ZERO;
                end else if (r_cnt == c_STABLE) begin
                    w_state = IDLE_LOW;
                    w_cnt   = c_ZERO;
                    w_clean = 1'b0;
                    w_fall  = 1'b1;
                end else begin
                    w_cnt = r_cnt + c_ONE;
                end
            end
            default: begin
                w_state  = IDLE_LOW;
                w_cnt    = c_ZERO;
                w_clean  = 1'b0;
                w_toggle = 1'b0;
            end
        endcase
    end

    assign Clean    = r_clean;
    assign notClean = ~r_clean;
    assign Rise     = r_rise;
    assign Fall     = r_fall;
    assign Toggle   = r_toggle;

endmodule
`default_nettype wire
